// File: rtl/synth_pkg.sv
// Shared types and constants for the voice divider scheduler: default sizing,
// datapath widths and the scheduler state encoding.
package synth_pkg;

    localparam int NUM_VOICES_DEFAULT  = 4;
    localparam int DIV_LATENCY_DEFAULT = 12;
    localparam int SAMPLE_W            = 8;
    localparam int COUNT_W             = 16;
    localparam int IDX_W               = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } sched_state_t;

endpackage

// File: rtl/next_voice_finder.sv
// Combinational search for the lowest set mask bit at or above a start index.
module next_voice_finder
    import synth_pkg::*;
#(
    parameter int N = NUM_VOICES_DEFAULT
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk downwards so the last hit written is the lowest qualifying index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (IDX_W'(i) >= start)) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_div_scheduler.sv
// Time-shares one external sequential divider among the oscillator voices,
// producing one scaled sample per enabled voice on every audio frame tick.
module voice_div_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES  = NUM_VOICES_DEFAULT,
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [COUNT_W*NUM_VOICES-1:0]  osc_count_flat,
    input  logic [COUNT_W*NUM_VOICES-1:0]  divisor_flat,
    output logic                           div_sample_now,
    output logic [COUNT_W-1:0]             div_oscillator_out,
    output logic [COUNT_W-1:0]             div_divisor,
    input  logic [SAMPLE_W-1:0]            div_q_out,
    output logic [SAMPLE_W*NUM_VOICES-1:0] sample_out_flat,
    output logic                           frame_valid,
    output logic                           busy,
    output logic                           overrun,
    output sched_state_t                   dbg_state
);

    localparam int CNT_W = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;

    sched_state_t                           state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [CNT_W-1:0]                       wait_q, wait_d;
    logic [NUM_VOICES-1:0]                  en_snap_q, en_snap_d;
    logic [NUM_VOICES-1:0][COUNT_W-1:0]     cnt_snap_q, cnt_snap_d;
    logic [NUM_VOICES-1:0][COUNT_W-1:0]     div_snap_q, div_snap_d;
    logic [NUM_VOICES-1:0][SAMPLE_W-1:0]    sample_q, sample_d;
    logic [COUNT_W-1:0]                     op_osc_q, op_osc_d;
    logic [COUNT_W-1:0]                     op_div_q, op_div_d;
    logic                                   overrun_q, overrun_d;

    logic [NUM_VOICES-1:0] eligible;
    logic                  found;
    logic [IDX_W-1:0]      found_idx;

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            eligible[i] = en_snap_q[i] && (div_snap_q[i] != '0);
        end
    end

    next_voice_finder #(.N(NUM_VOICES)) u_finder (
        .mask  (eligible),
        .start (idx_q),
        .found (found),
        .idx   (found_idx)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wait_q     <= '0;
            en_snap_q  <= '0;
            cnt_snap_q <= '0;
            div_snap_q <= '0;
            sample_q   <= '0;
            op_osc_q   <= '0;
            op_div_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            en_snap_q  <= en_snap_d;
            cnt_snap_q <= cnt_snap_d;
            div_snap_q <= div_snap_d;
            sample_q   <= sample_d;
            op_osc_q   <= op_osc_d;
            op_div_q   <= op_div_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        en_snap_d  = en_snap_q;
        cnt_snap_d = cnt_snap_q;
        div_snap_d = div_snap_q;
        sample_d   = sample_q;
        op_osc_d   = op_osc_q;
        op_div_d   = op_div_q;
        overrun_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (sample_tick) begin
                    en_snap_d  = voice_en;
                    cnt_snap_d = osc_count_flat;
                    div_snap_d = divisor_flat;
                    idx_d      = '0;
                    state_d    = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                // Every slot passed over on the way to the next hit is ineligible.
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if ((IDX_W'(i) >= idx_q) && (!found || (IDX_W'(i) < found_idx))) begin
                        sample_d[i] = '0;
                    end
                    if (found && (IDX_W'(i) == found_idx)) begin
                        op_osc_d = cnt_snap_q[i];
                        op_div_d = div_snap_q[i];
                    end
                end
                idx_d   = found ? found_idx : idx_q;
                state_d = found ? ISSUE : DONE;
            end
            ISSUE: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == CNT_W'(DIV_LATENCY - 2)) begin
                    state_d = CAPTURE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CAPTURE: begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (IDX_W'(i) == idx_q) begin
                        sample_d[i] = div_q_out;
                    end
                end
                idx_d   = idx_q + 1'b1;
                state_d = SCAN;
            end
            default: state_d = IDLE;
        endcase
        if (sample_tick && (state_q != IDLE) && (state_q != DONE)) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        busy           = (state_q == SCAN) || (state_q == ISSUE) ||
                         (state_q == WAIT) || (state_q == CAPTURE);
        frame_valid    = (state_q == DONE);
        div_sample_now = (state_q == ISSUE);
    end

    assign div_oscillator_out = op_osc_q;
    assign div_divisor        = op_div_q;
    assign sample_out_flat    = sample_q;
    assign overrun            = overrun_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_voice_div_scheduler.sv
// Directed bench for voice_div_scheduler with a behavioural divider model
// returning min(255, count*256/divisor) a fixed latency after each start pulse.
module tb_voice_div_scheduler;
    import synth_pkg::*;

    localparam int NV = 4;
    localparam int L  = 12;

    logic              clk;
    logic              nrst;
    logic              sample_tick;
    logic [NV-1:0]     voice_en;
    logic [16*NV-1:0]  osc_count_flat;
    logic [16*NV-1:0]  divisor_flat;
    logic              div_sample_now;
    logic [15:0]       div_oscillator_out;
    logic [15:0]       div_divisor;
    logic [7:0]        div_q_out;
    logic [8*NV-1:0]   sample_out_flat;
    logic              frame_valid;
    logic              busy;
    logic              overrun;
    sched_state_t      dbg_state;

    int checks;
    int failures;
    int sn_cnt;

    voice_div_scheduler #(.NUM_VOICES(NV), .DIV_LATENCY(L)) dut (
        .clk                (clk),
        .nrst               (nrst),
        .sample_tick        (sample_tick),
        .voice_en           (voice_en),
        .osc_count_flat     (osc_count_flat),
        .divisor_flat       (divisor_flat),
        .div_sample_now     (div_sample_now),
        .div_oscillator_out (div_oscillator_out),
        .div_divisor        (div_divisor),
        .div_q_out          (div_q_out),
        .sample_out_flat    (sample_out_flat),
        .frame_valid        (frame_valid),
        .busy               (busy),
        .overrun            (overrun),
        .dbg_state          (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] div_model(input logic [15:0] osc, input logic [15:0] dv);
        int t;
        if (dv == 16'd0) return 8'd0;
        t = (int'(osc) * 256) / int'(dv);
        return (t > 255) ? 8'd255 : 8'(t);
    endfunction

    logic [7:0] pend_q;
    int         lat_cnt;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_q_out <= 8'd0;
            pend_q    <= 8'd0;
            lat_cnt   <= 0;
        end else if (div_sample_now) begin
            pend_q    <= div_model(div_oscillator_out, div_divisor);
            div_q_out <= 8'd0;
            lat_cnt   <= L - 1;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) div_q_out <= pend_q;
        end
    end

    always @(posedge clk) begin
        if (div_sample_now) sn_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_samples"}, 64'(sample_out_flat), 64'd0);
        check({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
        check({tag, "_sample_now"}, 64'(div_sample_now), 64'd0);
        check({tag, "_op_osc"}, 64'(div_oscillator_out), 64'd0);
        check({tag, "_op_div"}, 64'(div_divisor), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // Issues one tick just after a clock edge and follows the frame to frame_valid.
    task automatic run_frame(input string tag, input int exp_lat, input int exp_sn,
                             input bit inject_ovr, input bit mutate, input bit do_reset);
        int n;
        bit fv;
        n  = 0;
        fv = 1'b0;
        sn_cnt = 0;
        sample_tick = 1'b1;
        while (!fv && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                sample_tick = 1'b0;
                check({tag, "_busy"}, 64'(busy), 64'd1);
            end
            if (inject_ovr) begin
                if (n == 20) sample_tick = 1'b1;
                if (n == 21) begin
                    sample_tick = 1'b0;
                    check({tag, "_overrun_hi"}, 64'(overrun), 64'd1);
                end
                if (n == 22) check({tag, "_overrun_lo"}, 64'(overrun), 64'd0);
            end
            if (mutate && n == 6) begin
                check({tag, "_op_at_tick"}, 64'(div_oscillator_out), 64'd22000);
                osc_count_flat = {16'd100, 16'd200, 16'd300, 16'd400};
            end
            if (mutate && n == 10) check({tag, "_op_held"}, 64'(div_oscillator_out), 64'd22000);
            if (do_reset && n == 6) begin
                nrst = 1'b0;
                #1;
                check_reset_values({tag, "_midreset"});
                #1;
                nrst = 1'b1;
                return;
            end
            if (frame_valid) fv = 1'b1;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_sample_now_count"}, 64'(sn_cnt), 64'(exp_sn));
        @(posedge clk);
        #1;
        check({tag, "_fv_one_cycle"}, 64'(frame_valid), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic cfg_four();
        voice_en       = 4'b1111;
        osc_count_flat = {16'd0, 16'd22727, 16'd22256, 16'd22000};
        divisor_flat   = {4{16'd22727}};
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        sn_cnt      = 0;
        nrst        = 1'b0;
        sample_tick = 1'b0;
        voice_en    = '0;
        osc_count_flat = '0;
        divisor_flat   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        nrst = 1'b1;
        @(posedge clk);
        #1;

        voice_en       = 4'b0001;
        osc_count_flat = {16'd0, 16'd0, 16'd0, 16'd22000};
        divisor_flat   = {4{16'd22727}};
        run_frame("single", 16, 1, 1'b0, 1'b0, 1'b0);
        check("single_samples", 64'(sample_out_flat), 64'({8'd0, 8'd0, 8'd0, 8'd247}));

        cfg_four();
        run_frame("four", 58, 4, 1'b0, 1'b0, 1'b0);
        check("four_samples", 64'(sample_out_flat), 64'({8'd0, 8'd255, 8'd250, 8'd247}));

        voice_en       = 4'b1101;
        osc_count_flat = {16'd11363, 16'd22727, 16'd22256, 16'd22000};
        divisor_flat   = {16'd22727, 16'd0, 16'd22727, 16'd22727};
        run_frame("skip", 30, 2, 1'b0, 1'b0, 1'b0);
        check("skip_samples", 64'(sample_out_flat), 64'({8'd127, 8'd0, 8'd0, 8'd247}));

        cfg_four();
        run_frame("ovr", 58, 4, 1'b1, 1'b0, 1'b0);
        check("ovr_samples", 64'(sample_out_flat), 64'({8'd0, 8'd255, 8'd250, 8'd247}));

        cfg_four();
        run_frame("snap", 58, 4, 1'b0, 1'b1, 1'b0);
        check("snap_samples", 64'(sample_out_flat), 64'({8'd0, 8'd255, 8'd250, 8'd247}));

        cfg_four();
        run_frame("rst", 0, 0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("rst_held_idle", 64'(dbg_state), 64'(IDLE));
        run_frame("after_rst", 58, 4, 1'b0, 1'b0, 1'b0);
        check("after_rst_samples", 64'(sample_out_flat), 64'({8'd0, 8'd255, 8'd250, 8'd247}));

        voice_en = 4'b0000;
        run_frame("empty", 2, 0, 1'b0, 1'b0, 1'b0);
        check("empty_samples", 64'(sample_out_flat), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
